// File: rtl/scr1_dmi_ext_pkg.sv
// Shared encodings for the extended DMI: DTMCS field positions, dmistat/op codes,
// TAP chain IDs and the request FSM state type.
package scr1_dmi_ext_pkg;

   localparam int unsigned SCR1_DBG_DMI_CH_ID_WIDTH = 2;
   localparam logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] SCR1_DBG_DMI_CH_ID_DTMCS = 2'd1;
   localparam logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] SCR1_DBG_DMI_CH_ID_DMI   = 2'd2;

   localparam int unsigned SCR1_DTMCS_W                = 32;
   localparam int unsigned SCR1_DTMCS_VERSION_LSB      = 0;
   localparam int unsigned SCR1_DTMCS_VERSION_W        = 4;
   localparam int unsigned SCR1_DTMCS_ABITS_LSB        = 4;
   localparam int unsigned SCR1_DTMCS_ABITS_W          = 6;
   localparam int unsigned SCR1_DTMCS_DMISTAT_LSB      = 10;
   localparam int unsigned SCR1_DTMCS_DMISTAT_W        = 2;
   localparam int unsigned SCR1_DTMCS_IDLE_LSB         = 12;
   localparam int unsigned SCR1_DTMCS_IDLE_W           = 3;
   localparam int unsigned SCR1_DTMCS_DMIRESET_BIT     = 16;
   localparam int unsigned SCR1_DTMCS_DMIHARDRESET_BIT = 17;

   localparam logic [1:0] SCR1_DMI_OP_SUCCESS = 2'd0;
   localparam logic [1:0] SCR1_DMI_OP_FAILED  = 2'd2;
   localparam logic [1:0] SCR1_DMI_OP_BUSY    = 2'd3;
   localparam logic [1:0] SCR1_DMI_OP_NOP     = 2'd0;
   localparam logic [1:0] SCR1_DMI_OP_READ    = 2'd1;
   localparam logic [1:0] SCR1_DMI_OP_WRITE   = 2'd2;

   typedef enum logic {
      SCR1_DMI_FSM_IDLE = 1'b0,
      SCR1_DMI_FSM_BUSY = 1'b1
   } scr1_dmi_fsm_e;

   function automatic int unsigned scr1_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/scr1_dmi_dr_shreg.sv
// TAP data register with a run-time active length: parallel capture, LSB-first
// shift with tdi entering at bit (len-1).
module scr1_dmi_dr_shreg #(
   parameter int unsigned MAX_W = 41,
   parameter int unsigned LEN_W = $clog2(MAX_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_capture,
   input  logic             i_shift,
   input  logic             i_tdi,
   input  logic [LEN_W-1:0] i_len,
   input  logic [MAX_W-1:0] i_cap_data,
   output logic [MAX_W-1:0] o_dr,
   output logic             o_tdo
);

   logic [MAX_W-1:0] r_dr;
   logic [MAX_W-1:0] w_mask;
   logic [MAX_W-1:0] w_shifted;

   // Bits at and above the active length are dropped so a short chain never
   // sees stale content from a longer one.
   always_comb begin
      w_mask    = (MAX_W'(1) << (i_len - LEN_W'(1))) - MAX_W'(1);
      w_shifted = ((r_dr >> 1) & w_mask) | (MAX_W'(i_tdi) << (i_len - LEN_W'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst)            r_dr <= '0;
      else if (i_capture) r_dr <= i_cap_data;
      else if (i_shift)   r_dr <= w_shifted;
   end

   assign o_dr  = r_dr;
   assign o_tdo = r_dr[0];

endmodule

// File: rtl/scr1_dmi_ext.sv
// Debug Module Interface: bridges the TAP DTMCS/DMI chains to a multi-cycle DM
// request/response handshake with timeout and sticky dmistat reporting.
module scr1_dmi_ext
   import scr1_dmi_ext_pkg::*;
#(
   parameter int unsigned ABITS     = 7,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned IDLE_HINT = 1,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                dtm_ch_sel,
   input  logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] dtm_ch_id,
   input  logic                                dtm_ch_capture,
   input  logic                                dtm_ch_shift,
   input  logic                                dtm_ch_update,
   input  logic                                dtm_ch_tdi,
   output logic                                dtm_ch_tdo,
   input  logic                                dmi_resp,
   input  logic                                dmi_resp_err,
   input  logic [DATA_W-1:0]                   dmi_rdata,
   output logic                                dmi_req,
   output logic                                dmi_wr,
   output logic [ABITS-1:0]                    dmi_addr,
   output logic [DATA_W-1:0]                   dmi_wdata
);

   localparam int unsigned DMI_W = ABITS + DATA_W + 2;
   localparam int unsigned DR_W  = scr1_max(DMI_W, SCR1_DTMCS_W);
   localparam int unsigned LEN_W = $clog2(DR_W + 1);
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   scr1_dmi_fsm_e     r_state, w_state_nxt;
   logic [1:0]        r_sticky, w_sticky_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [ABITS-1:0]  r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic              r_wr;

   logic                    w_sel_dtmcs, w_sel_dmi, w_busy;
   logic                    w_dtmcs_upd, w_dmi_upd, w_dmireset, w_hardreset;
   logic                    w_resp, w_timeout, w_issue, w_set_busy, w_set_fail;
   logic [1:0]              w_upd_op, w_cap_op;
   logic [DR_W-1:0]         w_dr, w_cap_data;
   logic [SCR1_DTMCS_W-1:0] w_dtmcs_cap;
   logic [LEN_W-1:0]        w_len;

   assign w_sel_dtmcs = dtm_ch_sel && (dtm_ch_id == SCR1_DBG_DMI_CH_ID_DTMCS);
   assign w_sel_dmi   = dtm_ch_sel && (dtm_ch_id == SCR1_DBG_DMI_CH_ID_DMI);
   assign w_busy      = (r_state == SCR1_DMI_FSM_BUSY);
   assign w_len       = w_sel_dmi ? LEN_W'(DMI_W) : LEN_W'(SCR1_DTMCS_W);

   assign w_dtmcs_upd = w_sel_dtmcs && dtm_ch_update;
   assign w_dmi_upd   = w_sel_dmi && dtm_ch_update;
   assign w_dmireset  = w_dtmcs_upd && w_dr[SCR1_DTMCS_DMIRESET_BIT];
   assign w_hardreset = w_dtmcs_upd && w_dr[SCR1_DTMCS_DMIHARDRESET_BIT];
   assign w_upd_op    = w_dr[1:0];

   // Hardreset overrides any completion or timeout arriving in the same cycle.
   assign w_cnt_nxt  = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_resp     = w_busy && dmi_resp && !w_hardreset;
   assign w_timeout  = w_busy && (TIMEOUT != 0) && !dmi_resp && !w_hardreset
                       && (w_cnt_nxt == CNT_W'(TIMEOUT));
   assign w_issue    = w_dmi_upd && !w_busy && (r_sticky == SCR1_DMI_OP_SUCCESS)
                       && ((w_upd_op == SCR1_DMI_OP_READ) || (w_upd_op == SCR1_DMI_OP_WRITE));
   assign w_set_busy = w_busy && ((w_sel_dmi && dtm_ch_capture) || w_dmi_upd);
   assign w_set_fail = (w_resp && dmi_resp_err) || w_timeout;

   always_comb begin
      w_cap_op    = w_busy ? SCR1_DMI_OP_BUSY : r_sticky;
      w_dtmcs_cap = '0;
      w_dtmcs_cap[SCR1_DTMCS_VERSION_LSB +: SCR1_DTMCS_VERSION_W] = SCR1_DTMCS_VERSION_W'(1);
      w_dtmcs_cap[SCR1_DTMCS_ABITS_LSB   +: SCR1_DTMCS_ABITS_W]   = SCR1_DTMCS_ABITS_W'(ABITS);
      w_dtmcs_cap[SCR1_DTMCS_DMISTAT_LSB +: SCR1_DTMCS_DMISTAT_W] = r_sticky;
      w_dtmcs_cap[SCR1_DTMCS_IDLE_LSB    +: SCR1_DTMCS_IDLE_W]    = SCR1_DTMCS_IDLE_W'(IDLE_HINT);
      w_cap_data  = w_sel_dmi ? DR_W'({r_addr, r_rdata, w_cap_op}) : DR_W'(w_dtmcs_cap);
   end

   scr1_dmi_dr_shreg #(.MAX_W(DR_W), .LEN_W(LEN_W)) u_dr (
      .clk        (clk),
      .rst        (rst),
      .i_capture  (dtm_ch_capture && (w_sel_dtmcs || w_sel_dmi)),
      .i_shift    (dtm_ch_shift && (w_sel_dtmcs || w_sel_dmi)),
      .i_tdi      (dtm_ch_tdi),
      .i_len      (w_len),
      .i_cap_data (w_cap_data),
      .o_dr       (w_dr),
      .o_tdo      (dtm_ch_tdo)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= SCR1_DMI_FSM_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SCR1_DMI_FSM_IDLE: if (w_issue) w_state_nxt = SCR1_DMI_FSM_BUSY;
         SCR1_DMI_FSM_BUSY: if (w_hardreset || dmi_resp || w_timeout) w_state_nxt = SCR1_DMI_FSM_IDLE;
         default:           w_state_nxt = SCR1_DMI_FSM_IDLE;
      endcase
   end

   always_comb begin
      dmi_req = (r_state == SCR1_DMI_FSM_BUSY);
   end

   // Sticky status: cleared by (hard)reset of dmistat, otherwise frozen once set.
   always_comb begin
      w_sticky_nxt = r_sticky;
      if (w_dmireset || w_hardreset) w_sticky_nxt = SCR1_DMI_OP_SUCCESS;
      if ((r_sticky == SCR1_DMI_OP_SUCCESS) || w_dmireset || w_hardreset) begin
         if (w_set_fail)      w_sticky_nxt = SCR1_DMI_OP_FAILED;
         else if (w_set_busy) w_sticky_nxt = SCR1_DMI_OP_BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= SCR1_DMI_OP_SUCCESS;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wr     <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_sticky <= w_sticky_nxt;
         if (w_issue)     r_cnt <= '0;
         else if (w_busy) r_cnt <= w_cnt_nxt;
         if (w_issue) begin
            r_addr  <= w_dr[DMI_W-1 -: ABITS];
            r_wdata <= w_dr[DATA_W+1:2];
            r_wr    <= (w_upd_op == SCR1_DMI_OP_WRITE);
         end
         if (w_resp && !dmi_resp_err && !r_wr) r_rdata <= dmi_rdata;
      end
   end

   assign dmi_wr    = r_wr;
   assign dmi_addr  = r_addr;
   assign dmi_wdata = r_wdata;

endmodule
